// File: rtl/inst_rom.sv
// inst_rom: synchronous instruction memory with word load port, fetch fault detection and error counting
module inst_rom #(
  parameter int DEPTH_LOG2 = 10,
  parameter logic [31:0] BASE_ADDR = 32'hbfc0_0000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ce,
  input  logic [31:0]           pc,
  output logic [31:0]           inst,
  output logic                  inst_valid,
  output logic                  addr_err,
  output logic [31:0]           bad_pc,
  output logic [7:0]            err_cnt,
  input  logic                  load_en,
  input  logic [DEPTH_LOG2-1:0] load_addr,
  input  logic [31:0]           load_data
);
  localparam logic [32:0] LIMIT = 33'd4 << DEPTH_LOG2;
  logic [31:0] mem [2**DEPTH_LOG2];
  logic [31:0] off;
  logic [DEPTH_LOG2-1:0] idx;
  logic fault;
  logic [31:0] rd;
  always_comb begin
    off = pc - BASE_ADDR;
    idx = off[DEPTH_LOG2+1:2];
    fault = (pc[1:0] != 2'd0) || ({1'b0, off} >= LIMIT);
    rd = (load_en && load_addr == idx) ? load_data : mem[idx];
  end
  always_ff @(posedge clk)
    if (load_en) mem[load_addr] <= load_data;
  always_ff @(posedge clk)
    if (!rst) begin
      inst <= '0;
      inst_valid <= 1'b0;
      addr_err <= 1'b0;
      bad_pc <= '0;
      err_cnt <= '0;
    end else begin
      inst <= (ce && !fault) ? rd : '0;
      inst_valid <= ce && !fault;
      addr_err <= ce && fault;
      if (ce && fault) begin
        bad_pc <= pc;
        err_cnt <= err_cnt + 8'(err_cnt != 8'hff);
      end
    end
endmodule

// File: tb/tb_inst_rom.sv
// tb_inst_rom: directed vector table, saturation/reset sequences and randomized checks against a behavioural model
module tb_inst_rom;
  localparam logic [31:0] BASE = 32'hbfc0_0000;
  logic clk = 1'b0;
  logic rst, ce, load_en;
  logic [31:0] pc, load_data;
  logic [9:0] load_addr;
  logic [31:0] inst, bad_pc;
  logic inst_valid, addr_err;
  logic [7:0] err_cnt;
  int tests = 0;
  int fails = 0;
  logic [31:0] m [1024];
  logic [31:0] e_inst, e_bad;
  logic e_valid, e_err;
  logic [7:0] e_cnt;
  typedef struct {
    logic r, c, le;
    logic [31:0] p;
    logic [9:0] la;
    logic [31:0] ld;
    logic [31:0] x_inst;
    logic x_valid, x_err;
    logic [31:0] x_bad;
    logic [7:0] x_cnt;
  } vec_t;
  vec_t tbl [15];

  inst_rom dut (
    .clk(clk), .rst(rst), .ce(ce), .pc(pc), .inst(inst), .inst_valid(inst_valid),
    .addr_err(addr_err), .bad_pc(bad_pc), .err_cnt(err_cnt),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data)
  );

  always #5 clk = ~clk;

  function automatic vec_t v(logic r, logic c, logic [31:0] p, logic le, logic [9:0] la, logic [31:0] ld,
                             logic [31:0] xi, logic xv, logic xe, logic [31:0] xb, logic [7:0] xc);
    vec_t t;
    t.r = r; t.c = c; t.p = p; t.le = le; t.la = la; t.ld = ld;
    t.x_inst = xi; t.x_valid = xv; t.x_err = xe; t.x_bad = xb; t.x_cnt = xc;
    return t;
  endfunction

  task automatic model_edge();
    logic [31:0] off;
    off = pc - BASE;
    if (load_en) m[load_addr] = load_data;
    if (!rst) begin
      e_inst = 0; e_valid = 0; e_err = 0; e_bad = 0; e_cnt = 0;
    end else if (!ce) begin
      e_inst = 0; e_valid = 0; e_err = 0;
    end else if (pc % 4 != 0 || off >= 4096) begin
      e_inst = 0; e_valid = 0; e_err = 1; e_bad = pc;
      e_cnt = (e_cnt == 255) ? 8'd255 : e_cnt + 8'd1;
    end else begin
      e_inst = m[off / 4]; e_valid = 1; e_err = 0;
    end
  endtask

  task automatic cmp(string name, logic [31:0] xi, logic xv, logic xe, logic [31:0] xb, logic [7:0] xc);
    tests++;
    if (inst !== xi || inst_valid !== xv || addr_err !== xe || bad_pc !== xb || err_cnt !== xc) begin
      fails++;
      $display("FAIL %s: got inst=%h valid=%b err=%b bad_pc=%h cnt=%0d, want inst=%h valid=%b err=%b bad_pc=%h cnt=%0d",
               name, inst, inst_valid, addr_err, bad_pc, err_cnt, xi, xv, xe, xb, xc);
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic step_chk(string name);
    step();
    cmp(name, e_inst, e_valid, e_err, e_bad, e_cnt);
  endtask

  initial begin
    rst = 0; ce = 0; pc = BASE; load_en = 0; load_addr = 0; load_data = 0;
    e_inst = 0; e_valid = 0; e_err = 0; e_bad = 0; e_cnt = 0;
    for (int i = 0; i < 1024; i++) begin
      load_en = 1; load_addr = 10'(i);
      load_data = (i < 4) ? 32'h2401_0001 + 32'(i) : (i == 1023) ? 32'h2401_03ff : $urandom;
      step();
    end
    load_en = 0;
    tbl[0]  = v(0, 1, BASE,          0, 0, 0,            0,            0, 0, 0,            0);
    tbl[1]  = v(1, 1, BASE,          0, 0, 0,            32'h24010001, 1, 0, 0,            0);
    tbl[2]  = v(1, 1, BASE + 4,      0, 0, 0,            32'h24010002, 1, 0, 0,            0);
    tbl[3]  = v(1, 1, BASE + 8,      0, 0, 0,            32'h24010003, 1, 0, 0,            0);
    tbl[4]  = v(1, 1, BASE + 12,     0, 0, 0,            32'h24010004, 1, 0, 0,            0);
    tbl[5]  = v(1, 0, BASE,          0, 0, 0,            0,            0, 0, 0,            0);
    tbl[6]  = v(1, 1, 32'hbfc00002,  0, 0, 0,            0,            0, 1, 32'hbfc00002, 1);
    tbl[7]  = v(1, 1, 32'hbfc01000,  0, 0, 0,            0,            0, 1, 32'hbfc01000, 2);
    tbl[8]  = v(1, 1, 32'hbfbffffc,  0, 0, 0,            0,            0, 1, 32'hbfbffffc, 3);
    tbl[9]  = v(1, 1, 32'hbfc00ffc,  0, 0, 0,            32'h240103ff, 1, 0, 32'hbfbffffc, 3);
    tbl[10] = v(1, 0, 32'hbfc00002,  0, 0, 0,            0,            0, 0, 32'hbfbffffc, 3);
    tbl[11] = v(1, 1, 32'hbfc00014,  1, 5, 32'hdeadbeef, 32'hdeadbeef, 1, 0, 32'hbfbffffc, 3);
    tbl[12] = v(1, 1, 32'hbfc00014,  0, 0, 0,            32'hdeadbeef, 1, 0, 32'hbfbffffc, 3);
    tbl[13] = v(0, 1, BASE + 4,      0, 0, 0,            0,            0, 0, 0,            0);
    tbl[14] = v(1, 1, BASE,          0, 0, 0,            32'h24010001, 1, 0, 0,            0);
    for (int i = 0; i < 15; i++) begin
      rst = tbl[i].r; ce = tbl[i].c; pc = tbl[i].p;
      load_en = tbl[i].le; load_addr = tbl[i].la; load_data = tbl[i].ld;
      step();
      cmp($sformatf("vec%0d", i), tbl[i].x_inst, tbl[i].x_valid, tbl[i].x_err, tbl[i].x_bad, tbl[i].x_cnt);
    end
    load_en = 0; rst = 1; ce = 1;
    for (int i = 0; i < 300; i++) begin
      pc = BASE + 32'h1000 + 32'(4 * i) + 32'(i % 3);
      step_chk("sat");
    end
    cmp("sat_end", 0, 0, 1, BASE + 32'h1000 + 32'(4 * 299) + 32'(299 % 3), 8'hff);
    rst = 0;
    step();
    cmp("sat_rst", 0, 0, 0, 0, 0);
    rst = 1;
    for (int i = 0; i < 3000; i++) begin
      int r;
      rst = ($urandom_range(0, 63) != 0);
      ce = ($urandom_range(0, 7) != 0);
      r = $urandom_range(0, 9);
      pc = (r < 6) ? BASE + 32'(4 * $urandom_range(0, 1023)) :
           (r == 6) ? BASE + 32'h1000 + 32'(4 * $urandom_range(0, 15)) :
           (r == 7) ? BASE - 32'(4 * $urandom_range(1, 16)) :
           (r == 8) ? BASE + 32'(4 * $urandom_range(0, 1023)) + 32'($urandom_range(1, 3)) : $urandom;
      load_en = ($urandom_range(0, 3) == 0);
      load_addr = ($urandom_range(0, 2) == 0) ? 10'((pc - BASE) >> 2) : 10'($urandom);
      load_data = $urandom;
      step_chk("rand");
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
